bros_sprite_drawer: RTL and testbench

Draw engine for the Bros game screen. Accepts a draw command (sprite select plus top-left origin) and walks every pixel of the selected sprite. It drives the address of the Brick or Mario sprite ROM, realigns the ROM's colour output with the pixel coordinates, and emits one plot/x/y/colour write per cycle to the 160x120, 3-bit-colour VGA framebuffer adapter. Pixels that are transparent or off-screen are suppressed.

---
 rtl/bros_sprite_drawer.sv | 142 ++++++++++++++
 tb/tb_bros_sprite_drawer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bros_sprite_drawer.sv
// Sprite draw engine: walks a Brick or Mario ROM in raster order and
// streams plot/x/y/colour writes to the 160x120 framebuffer, 1 px/cycle.
module bros_sprite_drawer #(
  parameter int         BRICK_W     = 16,
  parameter int         BRICK_H     = 8,
  parameter int         MARIO_W     = 12,
  parameter int         MARIO_H     = 16,
  parameter logic [2:0] TRANSPARENT = 3'b000,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       sprite_sel_i,
  input  logic [7:0] x0_i,
  input  logic [6:0] y0_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [6:0] brick_addr_o,
  input  logic [2:0] brick_q_i,
  output logic [7:0] mario_addr_o,
  input  logic [2:0] mario_q_i,
  output logic       plot_o,
  output logic [7:0] x_out_o,
  output logic [6:0] y_out_o,
  output logic [2:0] colour_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       sel_q;
  logic [7:0] x0_q;
  logic [6:0] y0_q;
  logic [7:0] col_q, row_q;
  logic [7:0] w_cur, h_cur;
  logic       last_col, last_row;
  logic [7:0] pix_addr;

  logic       v1_q;
  logic [8:0] px1_q;
  logic [7:0] py1_q;
  logic       plot_q;
  logic [7:0] x_out_q;
  logic [6:0] y_out_q;
  logic [2:0] colour_q;
  logic [2:0] rom_q;
  logic       on_screen;

  assign w_cur    = sel_q ? 8'(MARIO_W) : 8'(BRICK_W);
  assign h_cur    = sel_q ? 8'(MARIO_H) : 8'(BRICK_H);
  assign last_col = (col_q == w_cur - 8'd1);
  assign last_row = (row_q == h_cur - 8'd1);
  assign pix_addr = row_q * w_cur + col_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_DRAW;
      S_DRAW:  if (last_col && last_row) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
    brick_addr_o = 7'd0;
    mario_addr_o = 8'd0;
    if (state_q == S_DRAW) begin
      if (sel_q) mario_addr_o = pix_addr;
      else       brick_addr_o = pix_addr[6:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sel_q <= 1'b0;
      x0_q  <= 8'd0;
      y0_q  <= 7'd0;
      col_q <= 8'd0;
      row_q <= 8'd0;
    end else if (state_q == S_IDLE && start_i) begin
      sel_q <= sprite_sel_i;
      x0_q  <= x0_i;
      y0_q  <= y0_i;
      col_q <= 8'd0;
      row_q <= 8'd0;
    end else if (state_q == S_DRAW) begin
      if (last_col) begin
        col_q <= 8'd0;
        row_q <= row_q + 8'd1;
      end else begin
        col_q <= col_q + 8'd1;
      end
    end
  end

  // Stage 1 lines the coordinates up with the ROM's registered data.
  assign rom_q     = sel_q ? mario_q_i : brick_q_i;
  assign on_screen = (px1_q < 9'(SCREEN_W)) && (py1_q < 8'(SCREEN_H));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      v1_q     <= 1'b0;
      px1_q    <= 9'd0;
      py1_q    <= 8'd0;
      plot_q   <= 1'b0;
      x_out_q  <= 8'd0;
      y_out_q  <= 7'd0;
      colour_q <= 3'd0;
    end else begin
      v1_q   <= (state_q == S_DRAW);
      px1_q  <= {1'b0, x0_q} + {1'b0, col_q};
      py1_q  <= {1'b0, y0_q} + row_q;
      plot_q <= v1_q && (rom_q != TRANSPARENT) && on_screen;
      if (v1_q) begin
        x_out_q  <= px1_q[7:0];
        y_out_q  <= py1_q[6:0];
        colour_q <= rom_q;
      end
    end
  end

  assign plot_o   = plot_q;
  assign x_out_o  = x_out_q;
  assign y_out_o  = y_out_q;
  assign colour_o = colour_q;

endmodule

// File: tb/tb_bros_sprite_drawer.sv
// Bench for bros_sprite_drawer: ROM models plus a per-cycle reference
// computed from raster index, origin and screen bounds.
module tb_bros_sprite_drawer;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       sprite_sel_i = 1'b0;
  logic [7:0] x0_i = 8'd0;
  logic [6:0] y0_i = 7'd0;
  logic       busy_o, done_o, plot_o;
  logic [6:0] brick_addr_o;
  logic [7:0] mario_addr_o;
  logic [2:0] brick_q_i = 3'd0;
  logic [2:0] mario_q_i = 3'd0;
  logic [7:0] x_out_o;
  logic [6:0] y_out_o;
  logic [2:0] colour_o;

  logic [2:0] brick_rom [128];
  logic [2:0] mario_rom [256];

  int checks = 0;
  int failures = 0;
  int nplots;

  bros_sprite_drawer dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .sprite_sel_i (sprite_sel_i),
    .x0_i         (x0_i),
    .y0_i         (y0_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .brick_addr_o (brick_addr_o),
    .brick_q_i    (brick_q_i),
    .mario_addr_o (mario_addr_o),
    .mario_q_i    (mario_q_i),
    .plot_o       (plot_o),
    .x_out_o      (x_out_o),
    .y_out_o      (y_out_o),
    .colour_o     (colour_o)
  );

  always #5 clock_i = ~clock_i;

  // Synchronous ROMs: registered address, data one cycle later.
  always @(posedge clock_i) begin
    brick_q_i <= brick_rom[brick_addr_o];
    mario_q_i <= mario_rom[mario_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0: addr[2:0]|1, 1: random, 2: even->0 odd->nonzero, 3: nonzero
  task automatic fill(input int mode);
    for (int a = 0; a < 256; a++) begin
      logic [2:0] c;
      case (mode)
        0: c = 3'(a) | 3'd1;
        1: c = 3'($urandom_range(0, 7));
        2: c = (a % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        default: c = 3'($urandom_range(1, 7));
      endcase
      if (a < 128) brick_rom[a] = c;
      mario_rom[a] = c;
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (E0).
  task automatic run_draw(input bit sel, input int x, input int y,
                          input int pa, input int pb, input int abort_at,
                          output int np);
    int w, h, n, last;
    w = sel ? 12 : 16;
    h = sel ? 16 : 8;
    n = w * h;
    last = (abort_at > 0) ? abort_at + 10 : n + 3;
    np = 0;
    start_i = 1'b1;
    sprite_sel_i = sel;
    x0_i = 8'(x);
    y0_i = 7'(y);
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    sprite_sel_i = 1'($urandom);
    x0_i = 8'($urandom);
    y0_i = 7'($urandom);
    for (int k = 1; k <= last; k++) begin
      @(negedge clock_i);
      if (plot_o === 1'b1) np++;
      if (abort_at > 0 && k > abort_at) begin
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_done", 32'(done_o), 0);
        chk("abort_plot", 32'(plot_o), 0);
        chk("abort_maddr", 32'(mario_addr_o), 0);
        chk("abort_baddr", 32'(brick_addr_o), 0);
        if (k == abort_at + 1) reset_i = 1'b0;
      end else begin
        int sa;
        sa = (k <= n) ? k - 1 : 0;
        chk("busy", 32'(busy_o), 32'(k <= n + 2));
        chk("done", 32'(done_o), 32'(k == n + 2));
        chk("brick_addr", 32'(brick_addr_o), sel ? 0 : sa);
        chk("mario_addr", 32'(mario_addr_o), sel ? sa : 0);
        if (k >= 3 && k <= n + 2) begin
          int i, px, py;
          logic [2:0] c;
          i = k - 3;
          px = x + i % w;
          py = y + i / w;
          c = sel ? mario_rom[i] : brick_rom[i];
          chk("plot", 32'(plot_o),
              32'(c != 3'd0 && px < 160 && py < 120));
          chk("x_out", 32'(x_out_o), px & 255);
          chk("y_out", 32'(y_out_o), py & 127);
          chk("colour", 32'(colour_o), 32'(c));
        end else begin
          chk("plot_idle", 32'(plot_o), 0);
        end
      end
      start_i = (k == pa || k == pb);
      if (k == abort_at) reset_i = 1'b1;
    end
    start_i = 1'b0;
  endtask

  initial begin
    fill(0);
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_plot", 32'(plot_o), 0);
    chk("rst_baddr", 32'(brick_addr_o), 0);
    chk("rst_maddr", 32'(mario_addr_o), 0);
    chk("rst_x", 32'(x_out_o), 0);
    chk("rst_y", 32'(y_out_o), 0);
    chk("rst_colour", 32'(colour_o), 0);
    reset_i = 1'b0;
    @(negedge clock_i);

    // Brick at origin with ignored starts in cycles 5 and 130
    run_draw(1'b0, 0, 0, 5, 130, 0, nplots);
    chk("brick_plots", 32'(nplots), 128);

    // Corner-clipped Mario, launched with minimum spacing
    fill(3);
    run_draw(1'b1, 150, 110, 0, 0, 0, nplots);
    chk("clip_plots", 32'(nplots), 100);

    fill(2);
    run_draw(1'b1, 20, 30, 0, 0, 0, nplots);
    chk("odd_plots", 32'(nplots), 96);

    // Mario aborted by reset in cycle 50
    fill(3);
    run_draw(1'b1, 40, 40, 0, 0, 50, nplots);
    @(negedge clock_i);

    // Back-to-back random draws with random ROM contents
    for (int t = 0; t < 8; t++) begin
      fill(1);
      run_draw(1'(t % 2 == 1 ? 1 : $urandom_range(0, 1)),
               int'($urandom_range(0, 255)),
               int'($urandom_range(0, 127)), 0, 0, 0, nplots);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
